// File: rtl/filter_cfg_arbiter.sv
// Two-requester arbiter/sequencer for the packet-filter configuration port.
// Serialises host and control-plane transactions and offers a lock for multi-register updates.
module filter_cfg_arbiter #(
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_write,
    input  logic [1:0]  req_lock,
    input  logic [3:0]  req_addr0,
    input  logic [3:0]  req_addr1,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        lock_active,
    output logic        lock_owner,
    output logic        cfg_we,
    output logic [3:0]  cfg_waddr,
    output logic [31:0] cfg_wdata,
    output logic [3:0]  cfg_raddr,
    input  logic [31:0] cfg_rdata
);

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] TIMEOUT_C = CW'(LOCK_TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, LOCKED} state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            owner_q, owner_d;
    logic            write_q, write_d;
    logic            lock_q, lock_d;
    logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [1:0]      rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            cfg_we_q, cfg_we_d;
    logic [AW-1:0]   cfg_waddr_q, cfg_waddr_d;
    logic [DW-1:0]   cfg_wdata_q, cfg_wdata_d;
    logic [AW-1:0]   cfg_raddr_q, cfg_raddr_d;
    logic            lock_active_q, lock_active_d;
    logic            lock_owner_q, lock_owner_d;

    logic [1:0]      ready_c;
    logic            accept_c;
    logic            acc_id_c;
    logic [CW-1:0]   idle_inc_c;

    // Arbitration, sequencing and lock bookkeeping
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        write_d       = write_q;
        lock_d        = lock_q;
        idle_cnt_d    = idle_cnt_q;
        rsp_valid_d   = 2'b00;
        rsp_rdata_d   = rsp_rdata_q;
        cfg_we_d      = 1'b0;
        cfg_waddr_d   = cfg_waddr_q;
        cfg_wdata_d   = cfg_wdata_q;
        cfg_raddr_d   = cfg_raddr_q;
        lock_active_d = lock_active_q;
        lock_owner_d  = lock_owner_q;
        ready_c       = 2'b00;
        accept_c      = 1'b0;
        acc_id_c      = 1'b0;
        idle_inc_c    = idle_cnt_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    // On contention the requester that did not win last time goes first
                    acc_id_c          = (&req_valid) ? ~last_grant_q : req_valid[1];
                    ready_c[acc_id_c] = 1'b1;
                    accept_c          = 1'b1;
                end
            end
            ISSUE: begin
                rsp_rdata_d          = write_q ? '0 : cfg_rdata;
                rsp_valid_d[owner_q] = 1'b1;
                state_d              = RESP;
            end
            RESP: begin
                if (lock_q) begin
                    state_d       = LOCKED;
                    lock_active_d = 1'b1;
                    lock_owner_d  = owner_q;
                    idle_cnt_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (req_valid[owner_q]) begin
                    acc_id_c         = owner_q;
                    ready_c[owner_q] = 1'b1;
                    accept_c         = 1'b1;
                end else if (idle_inc_c >= TIMEOUT_C) begin
                    state_d       = IDLE;
                    idle_cnt_d    = '0;
                    lock_active_d = 1'b0;
                end else begin
                    idle_cnt_d = idle_inc_c;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept_c) begin
            state_d       = ISSUE;
            owner_d       = acc_id_c;
            last_grant_d  = acc_id_c;
            write_d       = req_write[acc_id_c];
            lock_d        = req_lock[acc_id_c];
            idle_cnt_d    = '0;
            lock_active_d = 1'b0;
            // Config-port registers load at acceptance so they are live during ISSUE
            if (req_write[acc_id_c]) begin
                cfg_we_d    = 1'b1;
                cfg_waddr_d = acc_id_c ? req_addr1 : req_addr0;
                cfg_wdata_d = acc_id_c ? req_wdata1 : req_wdata0;
            end else begin
                cfg_raddr_d = acc_id_c ? req_addr1 : req_addr0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            write_q       <= 1'b0;
            lock_q        <= 1'b0;
            idle_cnt_q    <= '0;
            rsp_valid_q   <= 2'b00;
            rsp_rdata_q   <= '0;
            cfg_we_q      <= 1'b0;
            cfg_waddr_q   <= '0;
            cfg_wdata_q   <= '0;
            cfg_raddr_q   <= '0;
            lock_active_q <= 1'b0;
            lock_owner_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            write_q       <= write_d;
            lock_q        <= lock_d;
            idle_cnt_q    <= idle_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            cfg_we_q      <= cfg_we_d;
            cfg_waddr_q   <= cfg_waddr_d;
            cfg_wdata_q   <= cfg_wdata_d;
            cfg_raddr_q   <= cfg_raddr_d;
            lock_active_q <= lock_active_d;
            lock_owner_q  <= lock_owner_d;
        end
    end

    assign req_ready   = ready_c;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign cfg_we      = cfg_we_q;
    assign cfg_waddr   = cfg_waddr_q;
    assign cfg_wdata   = cfg_wdata_q;
    assign cfg_raddr   = cfg_raddr_q;
    assign lock_active = lock_active_q;
    assign lock_owner  = lock_owner_q;

endmodule

// File: tb/tb_filter_cfg_arbiter.sv
// Scoreboard bench for filter_cfg_arbiter: transaction-level reference model predicts grants,
// config-port activity and responses; a monitor compares them as the DUT presents them.
module tb_filter_cfg_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_write, req_lock, rsp_valid;
    logic [3:0]  req_addr0, req_addr1, cfg_waddr, cfg_raddr;
    logic [31:0] req_wdata0, req_wdata1, rsp_rdata, cfg_wdata, cfg_rdata;
    logic        lock_active, lock_owner, cfg_we;

    filter_cfg_arbiter #(.LOCK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_lock(req_lock),
        .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .lock_active(lock_active), .lock_owner(lock_owner),
        .cfg_we(cfg_we), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata), .cfg_raddr(cfg_raddr),
        .cfg_rdata(cfg_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    function automatic logic [31:0] seed(input logic [3:0] a);
        return (a == 4'd6) ? 32'h0000_63DD : {a, 12'hC0F, a, 12'h5A1};
    endfunction

    // Stand-in configuration register block
    logic [31:0] cmem [16];
    bit   [15:0] cvalid;
    always @(posedge clk) if (cfg_we) begin
        cmem[cfg_waddr]   <= cfg_wdata;
        cvalid[cfg_waddr] <= 1'b1;
    end
    assign cfg_rdata = cvalid[cfg_raddr] ? cmem[cfg_raddr] : seed(cfg_raddr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    task automatic fail_note(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, ncyc);
    endtask

    // Stimulus
    typedef struct {
        bit          wr;
        bit          lk;
        logic [3:0]  addr;
        logic [31:0] data;
        int          gap;
    } txn_t;

    txn_t txq0[$];
    txn_t txq1[$];
    txn_t cur[2];
    bit   act[2];
    int   wt[2];
    int   stall[2];

    initial begin
        logic [1:0] acc;
        req_valid = 2'b00; req_write = 2'b00; req_lock = 2'b00;
        req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
        act[0] = 0; act[1] = 0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    act[i] = 0; wt[i] = 0; stall[i] = 0;
                end else begin
                    if (act[i] && acc[i]) act[i] = 0;
                    if (!act[i]) begin
                        if (i == 0 && txq0.size() > 0) begin
                            cur[i] = txq0.pop_front(); act[i] = 1; wt[i] = cur[i].gap; stall[i] = 0;
                        end else if (i == 1 && txq1.size() > 0) begin
                            cur[i] = txq1.pop_front(); act[i] = 1; wt[i] = cur[i].gap; stall[i] = 0;
                        end
                    end
                end
                if (act[i] && wt[i] > 0) begin
                    req_valid[i] = 1'b0;
                    wt[i]--;
                end else begin
                    req_valid[i] = act[i];
                end
                if (req_valid[i]) begin
                    stall[i]++;
                    if (stall[i] > 400) begin
                        fail_note($sformatf("req%0d_never_accepted", i));
                        act[i] = 0;
                        req_valid[i] = 1'b0;
                    end
                end
                req_write[i] = cur[i].wr;
                req_lock[i]  = cur[i].lk;
                if (i == 0) begin req_addr0 = cur[i].addr; req_wdata0 = cur[i].data; end
                else        begin req_addr1 = cur[i].addr; req_wdata1 = cur[i].data; end
            end
        end
    end

    // Reference model and scoreboard
    typedef struct { int cyc; logic [3:0] addr; logic [31:0] data; } wexp_t;
    typedef struct { int cyc; logic [3:0] addr; } rexp_t;
    typedef struct { int cyc; bit who; logic [31:0] data; } sexp_t;

    wexp_t wq[$];
    rexp_t rq[$];
    sexp_t sq[$];
    logic [31:0] mmem [16];
    bit   [15:0] mvalid;
    int   m_busy = 0, m_idle = 0;
    bit   m_lk = 0, m_own = 0, m_locked = 0, m_last = 1;

    initial forever begin
        logic [1:0]  exp_rdy;
        bit          exp_la, acc_en, w;
        logic [3:0]  a;
        wexp_t       we;
        rexp_t       re;
        sexp_t       se;
        @(negedge clk);
        if (!rst_n) begin
            chk("reset_ctrl", 32'({req_ready, rsp_valid, cfg_we, lock_active, lock_owner}), 32'h0);
            chk("reset_rsp_rdata", rsp_rdata, 32'h0);
            chk("reset_cfg_wdata", cfg_wdata, 32'h0);
            chk("reset_cfg_addrs", 32'({cfg_waddr, cfg_raddr}), 32'h0);
            wq.delete(); rq.delete(); sq.delete();
            m_busy = 0; m_idle = 0; m_lk = 0; m_own = 0; m_locked = 0; m_last = 1;
        end else begin
            ncyc++;
            if (cfg_we) begin
                if (wq.size() == 0) fail_note("unexpected_cfg_we");
                else begin
                    we = wq.pop_front();
                    chk("cfg_we_cycle", 32'(ncyc), 32'(we.cyc));
                    chk("cfg_waddr", 32'(cfg_waddr), 32'(we.addr));
                    chk("cfg_wdata", cfg_wdata, we.data);
                    mmem[we.addr] = we.data;
                    mvalid[we.addr] = 1'b1;
                end
            end
            if (wq.size() > 0 && wq[0].cyc < ncyc) begin
                fail_note("missing_cfg_we");
                void'(wq.pop_front());
            end
            if (rq.size() > 0 && rq[0].cyc == ncyc) begin
                re = rq.pop_front();
                chk("cfg_raddr", 32'(cfg_raddr), 32'(re.addr));
            end
            if (rsp_valid != 2'b00) begin
                if (sq.size() == 0) fail_note("unexpected_rsp_valid");
                else begin
                    se = sq.pop_front();
                    chk("rsp_cycle", 32'(ncyc), 32'(se.cyc));
                    chk("rsp_valid", 32'(rsp_valid), se.who ? 32'h2 : 32'h1);
                    chk("rsp_rdata", rsp_rdata, se.data);
                end
            end
            if (sq.size() > 0 && sq[0].cyc < ncyc) begin
                fail_note("missing_rsp_valid");
                void'(sq.pop_front());
            end

            exp_rdy = 2'b00;
            exp_la  = m_locked && (m_busy == 0);
            acc_en  = 0;
            w       = 0;
            chk("lock_active", 32'(lock_active), 32'(exp_la));
            if (exp_la) chk("lock_owner", 32'(lock_owner), 32'(m_own));
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin m_locked = m_lk; m_idle = 0; end
            end else if (m_locked) begin
                if (req_valid[m_own]) begin
                    w = m_own; acc_en = 1;
                end else begin
                    m_idle++;
                    if (m_idle >= TO) m_locked = 0;
                end
            end else if (req_valid != 2'b00) begin
                w = (req_valid == 2'b11) ? !m_last : req_valid[1];
                acc_en = 1;
            end
            if (acc_en) exp_rdy[w] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (acc_en) begin
                a = w ? req_addr1 : req_addr0;
                m_busy = 2; m_lk = req_lock[w]; m_own = w; m_last = w; m_locked = 0;
                if (req_write[w]) begin
                    wq.push_back('{ncyc + 1, a, w ? req_wdata1 : req_wdata0});
                    sq.push_back('{ncyc + 2, w, 32'h0});
                end else begin
                    rq.push_back('{ncyc + 1, a});
                    sq.push_back('{ncyc + 2, w, mvalid[a] ? mmem[a] : seed(a)});
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (txq0.size() != 0 || txq1.size() != 0 || act[0] || act[1] ||
               wq.size() != 0 || sq.size() != 0 || m_busy != 0 || m_locked) begin
            @(posedge clk);
            n++;
            if (n > 3000) begin
                fail_note({name, "_timeout"});
                break;
            end
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        txq0.push_back('{1'b1, 1'b0, 4'h2, 32'h86DD, 0});
        wait_idle("single_write");
        txq1.push_back('{1'b0, 1'b0, 4'h6, 32'h0, 0});
        wait_idle("single_read");

        for (int k = 0; k < 10; k++) begin
            txq0.push_back('{1'b1, 1'b0, 4'(k), 32'hA000_0000 + 32'(k), 0});
            txq1.push_back('{1'b1, 1'b0, 4'(k), 32'hB000_0000 + 32'(k), 0});
        end
        wait_idle("alternate");

        txq1.push_back('{1'b1, 1'b1, 4'h0, 32'h0011_2233, 0});
        txq1.push_back('{1'b1, 1'b0, 4'h1, 32'h4455_6677, 0});
        txq0.push_back('{1'b1, 1'b0, 4'h0, 32'hDEAD_0000, 1});
        wait_idle("lock_pair");

        txq0.push_back('{1'b1, 1'b1, 4'h4, 32'h0A00_0000, 0});
        txq0.push_back('{1'b1, 1'b0, 4'h5, 32'hFFFF_FF00, 6});
        txq1.push_back('{1'b0, 1'b0, 4'h4, 32'h0, 2});
        wait_idle("lock_timeout");
        txq0.push_back('{1'b1, 1'b1, 4'h4, 32'h0B00_0000, 0});
        txq0.push_back('{1'b0, 1'b0, 4'h4, 32'h0, 5});
        txq1.push_back('{1'b1, 1'b0, 4'h5, 32'hFFFF_0000, 2});
        wait_idle("lock_retained");

        for (int k = 0; k < 40; k++) begin
            txq0.push_back('{1'($urandom), ($urandom_range(0, 2) == 0), 4'($urandom), $urandom,
                             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0});
            txq1.push_back('{1'($urandom), ($urandom_range(0, 2) == 0), 4'($urandom), $urandom,
                             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0});
        end
        wait_idle("random");

        txq0.push_back('{1'b1, 1'b0, 4'h3, 32'hCAFE_F00D, 0});
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!cfg_we && n < 50);
        if (!cfg_we) fail_note("reset_test_no_issue");
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            chk("post_reset_cfg_we", 32'(cfg_we), 32'h0);
            chk("post_reset_rsp_valid", 32'(rsp_valid), 32'h0);
        end
        txq1.push_back('{1'b0, 1'b0, 4'h3, 32'h0, 0});
        wait_idle("after_reset_read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_cfg_arbiter.md
# filter_cfg_arbiter

Two-requester arbiter and sequencer for the filter configuration register port. It shares the single write/read configuration interface of the packet-filter configuration block between a host management master (requester 0) and an on-chip control-plane agent (requester 1). It serialises their transactions, returns read data, and provides a lock so multi-register updates are not interleaved (e.g. MAC low/high at addresses 0x0/0x1, or IP base/mask at 0x4/0x5). It sits between the two masters and the configuration register block.

## Interface
Parameters:
- LOCK_TIMEOUT, 16: idle cycles a locked owner may hold the port before the lock is forcibly released; legal range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  2  per-requester transaction valid; bit i = requester i
- req_ready  out  2  per-requester accept; transfer occurs when valid & ready on the same bit
- req_write  in  2  per-requester: 1 = write, 0 = read
- req_lock  in  2  per-requester: retain ownership after this transaction
- req_addr0 / req_addr1  in  4  register address, requester 0 / 1
- req_wdata0 / req_wdata1  in  32  write data, requester 0 / 1
- rsp_valid  out  2  one-cycle completion pulse to the owning requester
- rsp_rdata  out  32  read data, valid with rsp_valid; 0 for writes
- lock_active  out  1  high while the port is held in LOCKED
- lock_owner  out  1  requester holding the lock; meaningful only when lock_active = 1
- cfg_we  out  1  write enable to the configuration block
- cfg_waddr  out  4  write address
- cfg_wdata  out  32  write data
- cfg_raddr  out  4  read address
- cfg_rdata  in  32  combinational read data from the configuration block

## Operation
- FSM states: IDLE, ISSUE, RESP, LOCKED. Reset state is IDLE.
- IDLE:
  - Winner is computed combinationally among valid requesters.
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester not equal to last_grant wins. last_grant resets to 1, so requester 0 wins the first contest.
  - req_ready is high for the winner only. On acceptance, the arbiter registers write/addr/wdata/lock and the owner id, updates last_grant, and goes to ISSUE.
- ISSUE (one cycle):
  - Write: cfg_we = 1, cfg_waddr/cfg_wdata = captured values.
  - Read: cfg_raddr = captured addr and cfg_rdata is sampled into a register; cfg_we = 0.
  - Next state: RESP.
- RESP (one cycle):
  - rsp_valid[owner] = 1 and rsp_rdata = sampled data (reads) or 0 (writes).
  - Next state: LOCKED if the captured lock = 1, else IDLE.
- LOCKED:
  - req_ready is high only for the owner, when it asserts req_valid. The other requester is stalled regardless of its valid.
  - On owner acceptance, go to ISSUE and clear the idle counter.
  - Each cycle the owner's req_valid is low, an 8-bit idle counter increments. When it reaches LOCK_TIMEOUT, return to IDLE with no response.
- An owner transaction with req_lock = 0 releases ownership after its RESP.
- Requests must be held stable by the master until accepted. Addresses outside 0x0–0x6 are forwarded unchanged: writes complete normally and reads return whatever cfg_rdata supplies.
- No response backpressure; rsp_valid is a one-cycle pulse.

## Timing
- Accept at cycle N:
  - cfg_we / cfg_raddr are driven in cycle N+1.
  - rsp_valid is high in cycle N+2.
  - The next acceptance is possible in cycle N+3. Throughput is one transaction per 3 cycles.
- cfg_we is a single-cycle pulse, only in ISSUE. cfg_waddr, cfg_wdata, cfg_raddr and rsp_rdata are registered and hold their last value outside their active cycle.
- req_ready is combinational from state, req_valid and last_grant. It is never high outside IDLE/LOCKED.
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, cfg_we 0, cfg_waddr 0, cfg_wdata 0, cfg_raddr 0, lock_active 0, lock_owner 0; last_grant 1; idle counter 0.
- Reset mid-transaction: the in-flight transaction is dropped, with no cfg_we and no rsp_valid after reset release. The lock is cleared.
- Timeout boundary: LOCK_TIMEOUT = 1 releases after the first idle cycle. If the owner asserts valid in the same cycle the counter would reach the limit, acceptance wins and the lock is kept.

## Test plan
- Single write, requester 0, addr 0x2, data 0x86DD at cycle N -> cfg_we = 1, cfg_waddr = 0x2, cfg_wdata = 0x86DD at N+1; rsp_valid = 2'b01 with rsp_rdata = 0 at N+2.
- Single read, requester 1, addr 0x6, with cfg_rdata = 0x63DD -> cfg_raddr = 0x6 at N+1; rsp_valid = 2'b10 with rsp_rdata = 0x63DD at N+2.
- Both requesters valid continuously, with writes tagged by requester -> grants alternate 0,1,0,1; the first grant after reset goes to 0; no starvation over 20 transactions.
- Lock sequence:
  - Stimulus: requester 1 writes addr 0x0 with lock = 1, then addr 0x1 with lock = 0, while requester 0 holds req_valid high throughout.
  - Required response: both requester-1 writes complete back-to-back with no requester-0 write between them; requester 0 is granted immediately after.
- Lock timeout with LOCK_TIMEOUT = 4: owner locks, then drops valid -> lock_active falls after 4 idle cycles and the other requester is granted next cycle. Also repeat with owner valid reasserted on the 4th idle cycle -> lock is retained.
- Assert rst_n low during ISSUE of a write -> after release, cfg_we stays 0, no rsp_valid, all outputs at reset values, state IDLE.
